// File: rtl/serial_add_ctrl_pkg.sv
// ============================================================================
// serial_add_ctrl_pkg : shared project definitions for the serial adder block
// Holds the controller state encodings and the default operand width.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_add_ctrl_full_adder.sv
// ============================================================================
// FULL_ADDER : single-bit full-adder cell used by the bit-serial datapath
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module FULL_ADDER (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// serial_add_ctrl : bit-serial add/subtract controller, LSB first, one bit/clk
// Optional signed-overflow output OVF when SERIAL_ADD_OVF_EN is defined.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] R,
  output logic             CO
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_co;
  logic             w_sum;
  logic             w_cout;
  logic             w_accept;
  logic             w_last;

  // START is honoured in IDLE and in FIN (back-to-back), never while running
  assign w_accept = START && (r_state != ST_RUN);
  assign w_last   = (r_cnt == C_LAST);

  FULL_ADDER u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (START) w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_FIN;
      ST_FIN:  w_next = START ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: invert B at load time and seed carry with SUB
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= B ^ {WIDTH{SUB}};
      r_carry <= SUB;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_r     <= {w_sum, r_r[WIDTH-1:1]};
      r_carry <= w_cout;
      r_cnt   <= w_last ? r_cnt : r_cnt + CW'(1);
      if (w_last) r_co <= w_cout;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;

  // During the last bit r_carry is the carry into the MSB
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ovf <= 1'b0;
    end else if (!w_accept && (r_state == ST_RUN) && w_last) begin
      r_ovf <= r_carry ^ w_cout;
    end
  end

  assign OVF = r_ovf;
`endif

  assign BUSY = (r_state == ST_RUN);
  assign DONE = (r_state == ST_FIN);
  assign R    = r_r;
  assign CO   = r_co;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// tb_serial_add_ctrl : scoreboard bench for serial_add_ctrl (WIDTH = 32)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

  localparam int W = 32;

  logic         CLK;
  logic         RST;
  logic         START;
  logic         SUB;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] R;
  logic         CO;
`ifdef SERIAL_ADD_OVF_EN
  logic         OVF;
`endif

  typedef struct {
    logic [W-1:0] r;
    logic         co;
    logic         ovf;
    int           acc_edge;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  int   n_chk   = 0;
  int   n_err   = 0;
  int   edge_cnt = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .SUB   (SUB),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .R     (R),
    .CO    (CO)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .OVF   (OVF)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  // Reference: plain integer arithmetic on WIDTH+1 bits
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t     e;
    logic [W:0] full;
    if (s) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else   full = {1'b0, a} + {1'b0, b};
    e.r  = full[W-1:0];
    e.co = full[W];
    if (s) e.ovf = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
    else   e.ovf = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
    e.acc_edge = 0;
    return e;
  endfunction

  // Monitor: every DONE pulse must match the oldest outstanding expectation
  always @(negedge CLK) begin
    if (DONE) begin
      n_chk++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got DONE=1 R=%h, required no DONE", R);
      end else begin
        exp_t e;
        logic ovf_act;
        e = q.pop_front();
`ifdef SERIAL_ADD_OVF_EN
        ovf_act = OVF;
`else
        ovf_act = e.ovf;
`endif
        if (R !== e.r || CO !== e.co || ovf_act !== e.ovf) begin
          n_err++;
          $display("FAIL result: got R=%h CO=%b OVF=%b, required R=%h CO=%b OVF=%b",
                   R, CO, ovf_act, e.r, e.co, e.ovf);
        end
        n_chk++;
        if (edge_cnt - e.acc_edge != W) begin
          n_err++;
          $display("FAIL latency: got %0d edges, required %0d", edge_cnt - e.acc_edge, W);
        end
      end
    end
  end

  // Called just after a falling edge; returns 1ns after the accepting edge
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    A = a; B = b; SUB = s; START = 1'b1;
    @(posedge CLK);
    #1;
    e = model(a, b, s);
    e.acc_edge = edge_cnt;
    q.push_back(e);
    last_exp = e;
    START = 1'b0;
  endtask

  // Waits (bounded) for DONE; optionally scrambles inputs and START while busy
  task automatic wait_done(input bit scramble, input int exp_busy);
    int busy_n = 0;
    bit got = 0;
    for (int i = 0; i < W + 4 && !got; i++) begin
      @(negedge CLK);
      if (DONE) begin
        got = 1;
        START = 1'b0;
      end else begin
        if (BUSY) busy_n++;
        if (scramble && BUSY) begin
          A = $urandom; B = $urandom; SUB = 1'($urandom); START = 1'($urandom);
        end else begin
          START = 1'b0;
        end
      end
    end
    n_chk++;
    if (!got) begin
      n_err++;
      $display("FAIL done_timeout: got no DONE within %0d cycles, required DONE", W + 4);
    end
    n_chk++;
    if (busy_n != exp_busy) begin
      n_err++;
      $display("FAIL busy_cycles: got %0d, required %0d", busy_n, exp_busy);
    end
  endtask

  task automatic hold_check();
    @(negedge CLK);
    n_chk++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || R !== last_exp.r || CO !== last_exp.co) begin
      n_err++;
      $display("FAIL hold_idle: got DONE=%b BUSY=%b R=%h CO=%b, required 0 0 %h %b",
               DONE, BUSY, R, CO, last_exp.r, last_exp.co);
    end
  endtask

  logic [W-1:0] dir_a [5] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0003, 32'h7FFF_FFFF};
  logic [W-1:0] dir_b [5] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0003, 32'h0000_0005, 32'h0000_0001};
  logic         dir_s [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    RST = 1'b1; START = 1'b0; SUB = 1'b0; A = '0; B = '0;
    #1;
    n_chk++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || R !== '0 || CO !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got BUSY=%b DONE=%b R=%h CO=%b, required all 0", BUSY, DONE, R, CO);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 5; i++) begin
      issue(dir_a[i], dir_b[i], dir_s[i]);
      wait_done(1'b0, W);
      hold_check();
    end

    // START mid-operation must be ignored
    issue(32'h0000_1234, 32'h0000_4321, 1'b0);
    repeat (10) @(negedge CLK);
    A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D; SUB = 1'b1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done(1'b0, W - 11);
    hold_check();

    // Back-to-back: START held in FIN
    issue(32'h1111_1111, 32'h2222_2222, 1'b0);
    wait_done(1'b0, W);
    issue(32'h8000_0000, 32'h0000_0001, 1'b1);
    n_chk++;
    if (BUSY !== 1'b1) begin
      n_err++;
      $display("FAIL back_to_back: got BUSY=%b, required 1", BUSY);
    end
    wait_done(1'b0, W);
    hold_check();

    // Randomized operations with inputs scrambled while busy
    for (int i = 0; i < 25; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      if (gap > 0) begin
        hold_check();
        repeat (gap - 1) @(negedge CLK);
      end
      issue($urandom, $urandom, 1'($urandom));
      wait_done(1'b1, W);
    end
    hold_check();

    // Asynchronous reset mid-operation
    issue(32'hCAFE_0000, 32'h0000_BABE, 1'b0);
    repeat (15) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    n_chk++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || R !== '0 || CO !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got BUSY=%b DONE=%b R=%h CO=%b, required all 0", BUSY, DONE, R, CO);
    end
    q.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (W + 4) @(negedge CLK);
    issue(32'h0000_0005, 32'h0000_0003, 1'b0);
    wait_done(1'b0, W);
    hold_check();

    repeat (3) @(negedge CLK);
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL pending_results: got %0d outstanding, required 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
